// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues data-cache requests for lw/sw/ll/sc, stalls until dhit,
// selects the word forwarded to MEM/WB and owns the LL/SC link register.
module mem_access_ctrl #(
    parameter int WORD_W  = 32,
    parameter bit LINK_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic [5:0]        opcode_MEM,
    input  logic [WORD_W-1:0] ALUOut_MEM,
    input  logic [WORD_W-1:0] WriteData_MEM,
    input  logic              advance,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] Output_Port_MEM,
    output logic              mem_stall,
    output logic [1:0]        dbgState,
    output logic              dbgLinkValid
);

    localparam logic [5:0] OP_LL = 6'h30;
    localparam logic [5:0] OP_SC = 6'h38;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2} stateT;

    stateT             state, nextState;
    logic              linkValid;
    logic [WORD_W-1:0] linkAddr;
    logic [WORD_W-1:0] holdData;
    logic [WORD_W-1:0] wordAddr;
    logic [WORD_W-1:0] result;
    logic [WORD_W-1:0] outSel;
    logic              isLL, isSC, scFail, memOp, scReject;
    logic              reqRead, reqWrite, stallReq, complete;

    assign wordAddr  = {ALUOut_MEM[WORD_W-1:2], 2'b00};
    assign isLL      = (opcode_MEM == OP_LL);
    assign isSC      = (opcode_MEM == OP_SC);
    assign scFail    = isSC & (!LINK_EN | !linkValid | (linkAddr != wordAddr));
    assign memOp     = valid_MEM & (MemRead_MEM | MemWrite_MEM) & !scFail;
    assign scReject  = valid_MEM & MemWrite_MEM & isSC & scFail;
    assign result    = MemRead_MEM ? dmemload :
                       (isSC ? WORD_W'(1) : ALUOut_MEM);

    // Request handshake: dmemREN/dmemWEN rise with the op and stay asserted, with address and
    // store data taken from the frozen EX/MEM register, up to and including the dhit cycle.
    always_comb begin
        nextState = state;
        reqRead   = 1'b0;
        reqWrite  = 1'b0;
        stallReq  = 1'b0;
        complete  = 1'b0;
        outSel    = ALUOut_MEM;
        case (state)
            IDLE: begin
                if (memOp) begin
                    reqRead  = MemRead_MEM;
                    reqWrite = MemWrite_MEM & ~MemRead_MEM;
                    if (dhit) begin
                        complete  = 1'b1;
                        outSel    = result;
                        nextState = advance ? IDLE : HOLD;
                    end else begin
                        stallReq  = 1'b1;
                        nextState = ACCESS;
                    end
                end else if (scReject) begin
                    outSel = '0;
                end
            end
            ACCESS: begin
                reqRead  = MemRead_MEM;
                reqWrite = MemWrite_MEM & ~MemRead_MEM;
                if (dhit) begin
                    complete  = 1'b1;
                    outSel    = result;
                    nextState = advance ? IDLE : HOLD;
                end else begin
                    stallReq = 1'b1;
                end
            end
            HOLD: begin
                outSel = holdData;
                if (advance) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Reset masks the combinational outputs so an in-flight request drops immediately.
    assign dmemREN         = reqRead & ~RST;
    assign dmemWEN         = reqWrite & ~RST;
    assign mem_stall       = stallReq & ~RST;
    assign Output_Port_MEM = RST ? '0 : outSel;
    assign dmemaddr        = wordAddr;
    assign dmemstore       = WriteData_MEM;
    assign dbgState        = state;
    assign dbgLinkValid    = linkValid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            holdData <= '0;
        end else begin
            state <= nextState;
            if (complete) holdData <= outSel;
        end
    end

    // LL completion takes priority over a coincident snoop or store to the linked word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            linkValid <= 1'b0;
            linkAddr  <= '0;
        end else if (LINK_EN && complete && MemRead_MEM && isLL) begin
            linkValid <= 1'b1;
            linkAddr  <= wordAddr;
        end else begin
            if (snoop_inv && (snoop_addr[WORD_W-1:2] == linkAddr[WORD_W-1:2]))
                linkValid <= 1'b0;
            if (complete && MemWrite_MEM && (isSC || (wordAddr == linkAddr)))
                linkValid <= 1'b0;
        end
    end

endmodule
